wb_arbiter_2: RTL and testbench
===============================

// Module: wb_arbiter_2
// PURPOSE
//  Two-master to one-slave Wishbone arbiter; the upstream counterpart of the 2-port address mux.
//  Lets two initiators (e.g. CPU and DMA) share one slave bus.
//  Grants ownership per bus cycle (cyc held) with round-robin tie-breaking.
//  Routes the owner's request to the slave and the slave's termination back to the owner only.
// PARAMETERS
//  DATA_WIDTH      32             data bus width in bits (8, 16, 32, 64)
//  ADDR_WIDTH      32             address bus width in bits
//  SELECT_WIDTH    DATA_WIDTH/8   byte select width
//  TIMEOUT_CYCLES  256            watchdog limit, >=2; used only with WB_ARB_TIMEOUT_EN
// PORTS
//  clk                   in   1             clock, all state on rising edge
//  rst                   in   1             asynchronous, active-high reset
//  wbm{0,1}_adr_i        in   ADDR_WIDTH    master N address
//  wbm{0,1}_dat_i        in   DATA_WIDTH    master N write data
//  wbm{0,1}_dat_o        out  DATA_WIDTH    read data to master N (wbs_dat_i broadcast)
//  wbm{0,1}_we_i         in   1             master N write enable
//  wbm{0,1}_sel_i        in   SELECT_WIDTH  master N byte select
//  wbm{0,1}_stb_i        in   1             master N strobe
//  wbm{0,1}_cyc_i        in   1             master N cycle; acts as bus request
//  wbm{0,1}_ack_o/err_o/rty_o  out  1 each  terminations to master N, gated by grant
//  wbs_adr_o/dat_o/sel_o out  ADDR/DATA/SEL owner's request fields; 0 when no owner
//  wbs_we_o/stb_o/cyc_o  out  1 each        owner's controls; 0 when no owner
//  wbs_dat_i             in   DATA_WIDTH    slave read data
//  wbs_ack_i/err_i/rty_i in   1 each        slave terminations
// BEHAVIOUR
//  - State: grant[1:0] one-hot (00 = idle), last (most recent owner), timeout counter.
//  - Reset: grant=00, last=1 (master 0 wins first tie), counter=0. All wbs_* and wbm*_ack/err/rty
//    outputs are 0; an asserted rst mid-cycle drops wbs_cyc_o/stb_o immediately (async).
//  - Idle: at each edge, requesters = cyc_i. One requester -> granted. Both -> the one != last.
//    Grant is registered: 1-cycle latency from cyc_i rise to wbs_cyc_o.
//  - Owned: grant held while owner's cyc_i=1 (locked/block transfers never split).
//    At the edge where owner's cyc_i=0: grant passes directly to the other master if it
//    requests (zero idle cycles), else 00. last updates whenever grant becomes non-zero.
//  - Datapath (combinational on grant): wbs_* = owner's fields; wbs_stb/cyc/we = owner's & grant.
//    wbmN_ack/err/rty_o = wbs_*_i & grant[N]; the non-owner sees 0 even when the slave acks.
//  - Simultaneous owner cyc drop + slave ack: ack passes to owner that cycle, then handover.
//  - No combinational path from wbs_ack_i to the grant mux select.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined: counter increments each cycle owner has stb_i=1 and no ack/err/rty;
//    clears on termination, stb_i=0 or grant change. At TIMEOUT_CYCLES-1: one-cycle err_o pulse
//    to owner, wbs_stb_o forced 0 that cycle, counter clears; grant kept until owner drops cyc.
//  Not defined: no counter logic; a hung slave stalls the owner indefinitely; TIMEOUT_CYCLES unused.
// STRUCTURE
//  Shared package wb_arb_pkg: GRANT_NONE/GRANT_M0/GRANT_M1 encodings, timeout counter width fn.
//  Sub-module wb_arb_rr_2: round-robin grant state (req[1:0], hold -> grant, last).
//  Top module holds datapath muxes, termination gating and optional watchdog.
// TESTING
//  m0 cyc/stb read @0x100, slave acks cycle 3 -> wbs_cyc_o 1 cycle after, m0 gets ack+data, m1 none.
//  m0,m1 cyc rise same cycle after reset -> m0 granted; repeat after release -> m1 granted.
//  m0 holds cyc for 4 stb/ack beats while m1 requests -> m1 waits; granted the edge m0 drops cyc.
//  m1 owns, slave asserts err -> wbm1_err_o=1, wbm0_err_o=0; rst pulse mid-cycle -> all outs 0.
//  TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> wbm0_err_o single pulse 8 cycles after stb.
//  Without TIMEOUT_EN, same stimulus for 300 cycles -> no err, grant held, stb remains 1.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared encodings and helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Bits needed to count 0 .. cycles-1 for the watchdog.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/wb_arb_rr_2.sv
// Round-robin grant state for two requesters; grant is held while the owner keeps requesting.
module wb_arb_rr_2
    import wb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] grant
);

    logic [1:0] grant_next;
    logic       last;
    logic       last_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= GRANT_NONE;
            last  <= 1'b1;
        end else begin
            grant <= grant_next;
            last  <= last_next;
        end
    end

    // On a tie the master that did not own the bus most recently wins.
    always_comb begin
        grant_next = grant;
        last_next  = last;
        if (!hold) begin
            case (req)
                2'b01:   grant_next = GRANT_M0;
                2'b10:   grant_next = GRANT_M1;
                2'b11:   grant_next = last ? GRANT_M0 : GRANT_M1;
                default: grant_next = GRANT_NONE;
            endcase
        end
        if (grant_next != GRANT_NONE) begin
            last_next = grant_next[1];
        end
    end

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master to one-slave Wishbone arbiter with per-cycle ownership and round-robin ties.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i
);

    logic [1:0] req;
    logic [1:0] grant;
    logic       hold;
    logic       owner_stb;
    logic       timeout_c;

    assign req  = {wbm1_cyc_i, wbm0_cyc_i};
    assign hold = |(grant & req);

    wb_arb_rr_2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .hold  (hold),
        .grant (grant)
    );

    // Request mux selected only by the registered grant.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        owner_stb = 1'b0;
        case (grant)
            GRANT_M0: begin
                wbs_adr_o = wbm0_adr_i;
                wbs_dat_o = wbm0_dat_i;
                wbs_sel_o = wbm0_sel_i;
                wbs_we_o  = wbm0_we_i;
                wbs_cyc_o = wbm0_cyc_i;
                owner_stb = wbm0_stb_i;
            end
            GRANT_M1: begin
                wbs_adr_o = wbm1_adr_i;
                wbs_dat_o = wbm1_dat_i;
                wbs_sel_o = wbm1_sel_i;
                wbs_we_o  = wbm1_we_i;
                wbs_cyc_o = wbm1_cyc_i;
                owner_stb = wbm1_stb_i;
            end
            default: ;
        endcase
    end

    assign wbs_stb_o  = owner_stb & ~timeout_c;

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;
    assign wbm0_ack_o = wbs_ack_i & grant[0];
    assign wbm1_ack_o = wbs_ack_i & grant[1];
    assign wbm0_err_o = (wbs_err_i | timeout_c) & grant[0];
    assign wbm1_err_o = (wbs_err_i | timeout_c) & grant[1];
    assign wbm0_rty_o = wbs_rty_i & grant[0];
    assign wbm1_rty_o = wbs_rty_i & grant[1];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             term;

    assign term      = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign timeout_c = owner_stb && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts stalled strobe cycles; any termination, idle strobe or ownership change restarts it.
    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if (!hold || !owner_stb || term || timeout_c) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end
`else
    // Watchdog compiled out; the parameter stays for interface compatibility.
    localparam bit TIMEOUT_CYCLES_OK = (TIMEOUT_CYCLES >= 2);
    assign timeout_c = 1'b0 & TIMEOUT_CYCLES_OK;
`endif

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Directed bench for wb_arbiter_2; the watchdog section follows WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter_2;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 256;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wbm0_adr_i, wbm1_adr_i, wbs_adr_o;
    logic [DW-1:0] wbm0_dat_i, wbm1_dat_i, wbm0_dat_o, wbm1_dat_o, wbs_dat_o, wbs_dat_i;
    logic [SW-1:0] wbm0_sel_i, wbm1_sel_i, wbs_sel_o;
    logic          wbm0_we_i, wbm0_stb_i, wbm0_cyc_i, wbm0_ack_o, wbm0_err_o, wbm0_rty_o;
    logic          wbm1_we_i, wbm1_stb_i, wbm1_cyc_i, wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
    logic          wbs_we_o, wbs_stb_o, wbs_cyc_o, wbs_ack_i, wbs_err_i, wbs_rty_i;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_arbiter_2 #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .SELECT_WIDTH   (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wbm0_adr_i (wbm0_adr_i),
        .wbm0_dat_i (wbm0_dat_i),
        .wbm0_dat_o (wbm0_dat_o),
        .wbm0_we_i  (wbm0_we_i),
        .wbm0_sel_i (wbm0_sel_i),
        .wbm0_stb_i (wbm0_stb_i),
        .wbm0_cyc_i (wbm0_cyc_i),
        .wbm0_ack_o (wbm0_ack_o),
        .wbm0_err_o (wbm0_err_o),
        .wbm0_rty_o (wbm0_rty_o),
        .wbm1_adr_i (wbm1_adr_i),
        .wbm1_dat_i (wbm1_dat_i),
        .wbm1_dat_o (wbm1_dat_o),
        .wbm1_we_i  (wbm1_we_i),
        .wbm1_sel_i (wbm1_sel_i),
        .wbm1_stb_i (wbm1_stb_i),
        .wbm1_cyc_i (wbm1_cyc_i),
        .wbm1_ack_o (wbm1_ack_o),
        .wbm1_err_o (wbm1_err_o),
        .wbm1_rty_o (wbm1_rty_o),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_we_o   (wbs_we_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_cyc_o  (wbs_cyc_o),
        .wbs_ack_i  (wbs_ack_i),
        .wbs_err_i  (wbs_err_i),
        .wbs_rty_i  (wbs_rty_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        wbm0_adr_i = '0; wbm0_dat_i = '0; wbm0_sel_i = '0;
        wbm0_we_i = 1'b0; wbm0_stb_i = 1'b0; wbm0_cyc_i = 1'b0;
        wbm1_adr_i = '0; wbm1_dat_i = '0; wbm1_sel_i = '0;
        wbm1_we_i = 1'b0; wbm1_stb_i = 1'b0; wbm1_cyc_i = 1'b0;
        wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    endtask

    initial begin
        logic err_seen;
        logic stb_dropped;

        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("reset_cyc", 64'(wbs_cyc_o), 64'd0);
        check("reset_stb", 64'(wbs_stb_o), 64'd0);
        check("reset_adr", 64'(wbs_adr_o), 64'd0);
        check("reset_ack0", 64'(wbm0_ack_o), 64'd0);
        rst = 1'b0;

        // Single master read: one cycle of grant latency, ack only to the owner.
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h100; wbm0_sel_i = 4'hf;
        settle();
        check("grant_latency_cyc", 64'(wbs_cyc_o), 64'd0);
        tick();
        check("m0_cyc", 64'(wbs_cyc_o), 64'd1);
        check("m0_stb", 64'(wbs_stb_o), 64'd1);
        check("m0_adr", 64'(wbs_adr_o), 64'h100);
        check("m0_sel", 64'(wbs_sel_o), 64'hf);
        check("m0_we", 64'(wbs_we_o), 64'd0);
        tick();
        wbs_ack_i = 1'b1; wbs_dat_i = 32'hdead_beef;
        settle();
        check("m0_ack", 64'(wbm0_ack_o), 64'd1);
        check("m0_rdata", 64'(wbm0_dat_o), 64'hdead_beef);
        check("m1_no_ack", 64'(wbm1_ack_o), 64'd0);
        wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
        tick();
        check("release_cyc", 64'(wbs_cyc_o), 64'd0);
        check("release_adr", 64'(wbs_adr_o), 64'd0);

        // Simultaneous requests after reset: m0 first, m1 on the next tie.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h200;
        wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1; wbm1_adr_i = 32'h300; wbm1_we_i = 1'b1;
        tick();
        check("tie1_adr", 64'(wbs_adr_o), 64'h200);
        check("tie1_we", 64'(wbs_we_o), 64'd0);
        wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
        tick();
        check("tie_idle_cyc", 64'(wbs_cyc_o), 64'd0);
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1;
        tick();
        check("tie2_adr", 64'(wbs_adr_o), 64'h300);
        check("tie2_we", 64'(wbs_we_o), 64'd1);
        wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
        wbm1_we_i = 1'b0;
        tick();

        // Locked block transfer: m1 waits out four beats, then takes over with no idle cycle.
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h400;
        tick();
        wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1; wbm1_adr_i = 32'h500;
        wbs_ack_i = 1'b1;
        for (int beat = 0; beat < 3; beat++) begin
            settle();
            check($sformatf("lock_adr_%0d", beat), 64'(wbs_adr_o), 64'h400);
            check($sformatf("lock_ack0_%0d", beat), 64'(wbm0_ack_o), 64'd1);
            check($sformatf("lock_ack1_%0d", beat), 64'(wbm1_ack_o), 64'd0);
            tick();
        end
        wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
        settle();
        check("drop_ack0", 64'(wbm0_ack_o), 64'd1);
        check("drop_ack1", 64'(wbm1_ack_o), 64'd0);
        check("drop_cyc", 64'(wbs_cyc_o), 64'd0);
        wbs_ack_i = 1'b0;
        tick();
        check("handover_adr", 64'(wbs_adr_o), 64'h500);
        check("handover_cyc", 64'(wbs_cyc_o), 64'd1);

        // Error routed only to m1, then an asynchronous reset mid-cycle.
        wbs_err_i = 1'b1;
        settle();
        check("err_m1", 64'(wbm1_err_o), 64'd1);
        check("err_m0", 64'(wbm0_err_o), 64'd0);
        rst = 1'b1;
        settle();
        check("arst_cyc", 64'(wbs_cyc_o), 64'd0);
        check("arst_stb", 64'(wbs_stb_o), 64'd0);
        check("arst_adr", 64'(wbs_adr_o), 64'd0);
        check("arst_err1", 64'(wbm1_err_o), 64'd0);
        clear_inputs();
        tick();
        rst = 1'b0;

        // Hung slave: the watchdog (if present) fires exactly once, eight cycles after strobe.
        wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_adr_i = 32'h600;
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("wd_err_%0d", i), 64'(wbm0_err_o), (i == 8) ? 64'd1 : 64'd0);
            check($sformatf("wd_stb_%0d", i), 64'(wbs_stb_o), (i == 8) ? 64'd0 : 64'd1);
            check($sformatf("wd_cyc_%0d", i), 64'(wbs_cyc_o), 64'd1);
        end
`else
        err_seen = 1'b0;
        stb_dropped = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            err_seen    = err_seen | wbm0_err_o;
            stb_dropped = stb_dropped | ~wbs_stb_o;
        end
        check("hang_no_err", 64'(err_seen), 64'd0);
        check("hang_stb_held", 64'(stb_dropped), 64'd0);
        check("hang_cyc", 64'(wbs_cyc_o), 64'd1);
        check("hang_adr", 64'(wbs_adr_o), 64'h600);
`endif
        clear_inputs();
        tick();
        check("final_idle", 64'(wbs_cyc_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
